// File: rtl/mem_ctrl.sv
// Load/store front end for the word-wide data memory; sub-word stores are read-modify-write.
// Optional alignment checking is enabled by defining MEM_CTRL_ALIGN_CHECK_EN.
`ifndef WRITE_ENABLE
`define WRITE_ENABLE 1'b1
`endif

module mem_ctrl #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic [ADDR_W+1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic              mem_rw_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;
  logic                misaligned;
  logic [DATA_W-1:0]   lane_data;
  logic [DATA_W-1:0]   merged;

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  assign misaligned = ((req_size_i == 2'b01) && req_addr_i[0]) ||
                      (req_size_i[1] && (req_addr_i[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Lane select uses only the address bits meaningful for the access size.
  always_comb begin
    lane_data = '0;
    case (size_q)
      2'b00:   lane_data[7:0]  = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
      2'b01:   lane_data[15:0] = mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
      default: lane_data       = mem_rdata_i;
    endcase
  end

  always_comb begin
    merged = rdata_q;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    req_ready_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          we_d         = req_we_i;
          size_d       = req_size_i;
          addr_d       = req_addr_i;
          wdata_d      = req_wdata_i;
          resp_rdata_d = '0;
          resp_err_d   = misaligned;
          if (misaligned)                     state_d = S_RESP;
          else if (!req_we_i || !req_size_i[1]) state_d = S_RD;
          else                                state_d = S_WR;
        end
      end
      S_RD: begin
        rdata_d = mem_rdata_i;
        if (we_q) begin
          state_d = S_WR;
        end else begin
          resp_rdata_d = lane_data;
          state_d      = S_RESP;
        end
      end
      S_WR:    state_d = S_RESP;
      S_RESP:  if (resp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Write enable decodes straight from state so an async reset drops it at once.
  assign mem_rw_o     = (state_q == S_WR) ? `WRITE_ENABLE : ~(`WRITE_ENABLE);
  assign mem_addr_o   = addr_q[ADDR_W+1:2];
  assign mem_wdata_o  = merged;
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized self-checking bench for mem_ctrl against a transaction-level memory model.
`ifndef WRITE_ENABLE
`define WRITE_ENABLE 1'b1
`endif

module tb_mem_ctrl;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [1:0]        req_size_i;
  logic [ADDR_W+1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic              resp_valid_o;
  logic              resp_ready_i;
  logic [DATA_W-1:0] resp_rdata_o;
  logic              resp_err_o;
  logic              mem_rw_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  int n_vec = 0;
  int n_err = 0;
  int we_cnt = 0;

  logic [31:0] mem     [0:4095] = '{default: '0};
  logic [31:0] ref_mem [0:4095] = '{default: '0};

  mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .mem_rw_o(mem_rw_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // Word memory behind the controller: combinational read, write on the clock.
  assign mem_rdata_i = mem[mem_addr_o];
  always @(posedge clk) begin
    if (mem_rw_o == `WRITE_ENABLE) begin
      mem[mem_addr_o] <= mem_wdata_o;
      we_cnt          <= we_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit ref_misaligned(input logic [1:0] size, input logic [13:0] addr);
`ifdef MEM_CTRL_ALIGN_CHECK_EN
    return (size == 2'd1 && addr[0]) || (size >= 2'd2 && addr[1:0] != 2'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic [13:0] addr);
    logic [31:0] w;
    w = ref_mem[addr[13:2]];
    if (size == 2'd0)      return (w >> (8 * addr[1:0])) & 32'hFF;
    else if (size == 2'd1) return (w >> (16 * addr[1])) & 32'hFFFF;
    else                   return w;
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [13:0] addr, input logic [31:0] d);
    logic [31:0] w, mask;
    int sh;
    w = ref_mem[addr[13:2]];
    if (size == 2'd0) begin
      sh = 8 * addr[1:0];
      mask = 32'hFF << sh;
      w = (w & ~mask) | ((d & 32'hFF) << sh);
    end else if (size == 2'd1) begin
      sh = 16 * addr[1];
      mask = 32'hFFFF << sh;
      w = (w & ~mask) | ((d & 32'hFFFF) << sh);
    end else begin
      w = d;
    end
    ref_mem[addr[13:2]] = w;
  endtask

  // One full transaction; called with the controller idle, #1 after a rising edge.
  task automatic do_txn(input logic we, input logic [1:0] size, input logic [13:0] addr,
                        input logic [31:0] wdata, input int hold);
    logic [31:0] exp_data, first_data;
    bit          mis;
    int          exp_lat, exp_we, lat, we0;
    mis      = ref_misaligned(size, addr);
    exp_data = (we || mis) ? 32'h0 : ref_load(size, addr);
    if (mis)                      exp_lat = 1;
    else if (we && size == 2'd0)  exp_lat = 3;
    else if (we && size == 2'd1)  exp_lat = 3;
    else                          exp_lat = 2;
    exp_we = (we && !mis) ? 1 : 0;
    if (we && !mis) ref_store(size, addr, wdata);

    req_we_i    = we;
    req_size_i  = size;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_valid_i = 1'b1;
    check_eq("req_ready_idle", {31'b0, req_ready_o}, 32'd1);
    we0 = we_cnt;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    req_addr_i  = 14'($urandom);
    lat = 1;
    while (!resp_valid_o && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("latency", lat, exp_lat);
    first_data = resp_rdata_o;
    for (int i = 0; i < hold; i++) begin
      check_eq("req_ready_busy", {31'b0, req_ready_o}, 32'd0);
      @(posedge clk); #1;
      check_eq("hold_valid", {31'b0, resp_valid_o}, 32'd1);
      check_eq("hold_rdata", resp_rdata_o, first_data);
    end
    check_eq("rdata", resp_rdata_o, exp_data);
    check_eq("err", {31'b0, resp_err_o}, {31'b0, mis});
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    resp_ready_i = 1'b0;
    check_eq("valid_after", {31'b0, resp_valid_o}, 32'd0);
    check_eq("ready_after", {31'b0, req_ready_o}, 32'd1);
    check_eq("we_pulses", we_cnt - we0, exp_we);
  endtask

  initial begin
    rst          = 1'b0;
    req_valid_i  = 1'b0;
    req_we_i     = 1'b0;
    req_size_i   = '0;
    req_addr_i   = '0;
    req_wdata_i  = '0;
    resp_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", {31'b0, resp_valid_o}, 32'd0);
    check_eq("rst_rdata", resp_rdata_o, 32'd0);
    check_eq("rst_err", {31'b0, resp_err_o}, 32'd0);
    check_eq("rst_rw", {31'b0, mem_rw_o}, {31'b0, ~(`WRITE_ENABLE)});
    check_eq("rst_addr", {20'b0, mem_addr_o}, 32'd0);
    check_eq("rst_wdata", mem_wdata_o, 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Directed sequence: word store, byte merge, lane loads, backpressure.
    do_txn(1'b1, 2'd2, 14'h010, 32'hDEADBEEF, 0);
    do_txn(1'b0, 2'd2, 14'h010, 32'h0, 0);
    do_txn(1'b1, 2'd0, 14'h013, 32'h000000AA, 0);
    do_txn(1'b0, 2'd2, 14'h010, 32'h0, 0);
    do_txn(1'b0, 2'd1, 14'h012, 32'h0, 0);
    do_txn(1'b0, 2'd0, 14'h011, 32'h0, 0);
    do_txn(1'b0, 2'd2, 14'h010, 32'h0, 5);
    do_txn(1'b0, 2'd2, 14'h011, 32'h0, 0);

    // Reset while a byte store sits in WR: the write must never land.
    req_we_i    = 1'b1;
    req_size_i  = 2'd0;
    req_addr_i  = 14'h021;
    req_wdata_i = 32'h55;
    req_valid_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    check_eq("wr_en", {31'b0, mem_rw_o}, {31'b0, `WRITE_ENABLE});
    #2 rst = 1'b0;
    #1;
    check_eq("rstwr_rw", {31'b0, mem_rw_o}, {31'b0, ~(`WRITE_ENABLE)});
    check_eq("rstwr_valid", {31'b0, resp_valid_o}, 32'd0);
    check_eq("rstwr_rdata", resp_rdata_o, 32'd0);
    check_eq("rstwr_addr", {20'b0, mem_addr_o}, 32'd0);
    check_eq("rstwr_wdata", mem_wdata_o, 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rstwr_ready", {31'b0, req_ready_o}, 32'd1);
    check_eq("rstwr_valid2", {31'b0, resp_valid_o}, 32'd0);
    do_txn(1'b0, 2'd2, 14'h020, 32'h0, 0);

    for (int i = 0; i < 80; i++) begin
      do_txn(1'($urandom), 2'($urandom), 14'($urandom_range(0, 63)),
             $urandom, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
